// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared states, source ids and widths for the UART transmit scheduler
// Used by uart_tx_sched and, when UART_SCHED_ECHO_EN is defined, uart_echo_fifo.
package uart_sched_pkg;

   localparam int BYTE_W          = 8;
   localparam int FRAME_BYTES_DEF = 36;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_IDLE
   } sched_state_t;

   typedef enum logic {
      SRC_ECHO,
      SRC_FRAME
   } sched_src_t;

endpackage

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - small synchronous byte FIFO holding received bytes awaiting echo
// Compiled only when UART_SCHED_ECHO_EN is defined; a pop frees room for a same-cycle push.
`ifdef UART_SCHED_ECHO_EN
module uart_echo_fifo
   import uart_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = BYTE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             push_ok, pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push_ok) begin
         mem_d[wr_q[AW-1:0]] = push_data;
         wr_d                = wr_q + (AW+1)'(1);
      end
      if (pop_ok) begin
         rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

endmodule
`endif

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - byte scheduler sharing one UART transmitter between echo bytes and frame dumps
// Echo FIFO and round-robin arbitration exist only when UART_SCHED_ECHO_EN is defined.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int ECHO_DEPTH  = 4,
   parameter int BUSY_TO     = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rdsig,
   input  logic [BYTE_W-1:0]             rxdata,
   input  logic                          fill_finish,
   input  logic [FRAME_BYTES*BYTE_W-1:0] fifo_data,
   input  logic                          tx_idle,
   output logic                          wrsig,
   output logic [BYTE_W-1:0]             dataout,
   output logic                          frame_busy,
   output logic                          frame_done,
   output logic                          frame_ovf,
   output logic                          echo_ovf
);

   localparam int IDX_W = $clog2(FRAME_BYTES);
   localparam int TO_W  = $clog2(BUSY_TO + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);

   sched_state_t state_q, state_d;
   sched_src_t   src_q, src_d, last_q, last_d;
   logic [FRAME_BYTES-1:0][BYTE_W-1:0] shadow_q, shadow_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [BYTE_W-1:0] dataout_q, dataout_d;
   logic              frame_busy_q, frame_busy_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_ovf_q, frame_ovf_d;
   logic              echo_req, echo_pop, pick_echo, byte_sent;
   logic [BYTE_W-1:0] echo_byte, frame_byte;

`ifdef UART_SCHED_ECHO_EN
   logic echo_full, echo_empty, echo_ovf_q, echo_ovf_d;

   uart_echo_fifo #(
      .DEPTH (ECHO_DEPTH),
      .WIDTH (BYTE_W)
   ) u_echo_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rdsig),
      .push_data (rxdata),
      .pop       (echo_pop),
      .pop_data  (echo_byte),
      .full      (echo_full),
      .empty     (echo_empty)
   );

   assign echo_req = ~echo_empty;
   assign echo_ovf = echo_ovf_q;

   always_comb begin
      echo_ovf_d = echo_ovf_q | (rdsig & echo_full & ~echo_pop);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         echo_ovf_q <= 1'b0;
      end else begin
         echo_ovf_q <= echo_ovf_d;
      end
   end
`else
   logic unused_echo;

   assign unused_echo = ^{rdsig, rxdata, echo_pop, 32'(ECHO_DEPTH)};
   assign echo_req    = 1'b0;
   assign echo_byte   = '0;
   assign echo_ovf    = 1'b0;
`endif

   // Byte 0 of a frame is the most significant byte of fifo_data.
   assign frame_byte = shadow_q[LAST_IDX - idx_q];

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      last_d       = last_q;
      shadow_d     = shadow_q;
      idx_d        = idx_q;
      to_d         = to_q;
      dataout_d    = dataout_q;
      frame_busy_d = frame_busy_q;
      frame_done_d = 1'b0;
      frame_ovf_d  = frame_ovf_q;
      echo_pop     = 1'b0;
      pick_echo    = 1'b0;
      byte_sent    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_idle && (echo_req || frame_busy_q)) begin
               pick_echo = echo_req && (!frame_busy_q || last_q == SRC_FRAME);
               if (pick_echo) begin
                  echo_pop  = 1'b1;
                  dataout_d = echo_byte;
                  src_d     = SRC_ECHO;
               end else begin
                  dataout_d = frame_byte;
                  src_d     = SRC_FRAME;
               end
               last_d  = src_d;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            to_d    = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A transmitter that never reports busy must not stall the scheduler.
            if (!tx_idle) begin
               state_d = WAIT_IDLE;
            end else if (to_q == TO_LAST) begin
               state_d   = IDLE;
               byte_sent = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (tx_idle) begin
               state_d   = IDLE;
               byte_sent = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (byte_sent && src_q == SRC_FRAME) begin
         if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            frame_busy_d = 1'b0;
            idx_d        = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (fill_finish) begin
         if (frame_busy_q) begin
            frame_ovf_d = 1'b1;
         end else begin
            shadow_d     = fifo_data;
            frame_busy_d = 1'b1;
            idx_d        = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         src_q        <= SRC_ECHO;
         last_q       <= SRC_ECHO;
         shadow_q     <= '0;
         idx_q        <= '0;
         to_q         <= '0;
         dataout_q    <= '0;
         frame_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_ovf_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         last_q       <= last_d;
         shadow_q     <= shadow_d;
         idx_q        <= idx_d;
         to_q         <= to_d;
         dataout_q    <= dataout_d;
         frame_busy_q <= frame_busy_d;
         frame_done_q <= frame_done_d;
         frame_ovf_q  <= frame_ovf_d;
      end
   end

   assign wrsig      = (state_q == ISSUE);
   assign dataout    = dataout_q;
   assign frame_busy = frame_busy_q;
   assign frame_done = frame_done_q;
   assign frame_ovf  = frame_ovf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched against a transaction-level model
// Echo expectations follow UART_SCHED_ECHO_EN; without it rdsig must be ignored.
module tb_uart_tx_sched;

   localparam int FB    = 36;
   localparam int DEPTH = 4;
   localparam int BTO   = 16;
   localparam logic [31:0] NONE = 32'hFFFF_FFFF;
`ifdef UART_SCHED_ECHO_EN
   localparam bit ECHO_EN = 1'b1;
`else
   localparam bit ECHO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            rdsig = 1'b0;
   logic [7:0]      rxdata = 8'h00;
   logic            fill_finish = 1'b0;
   logic [FB*8-1:0] fifo_data = '0;
   logic            tx_idle = 1'b1;
   logic            wrsig, frame_busy, frame_done, frame_ovf, echo_ovf;
   logic [7:0]      dataout;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .FRAME_BYTES (FB),
      .ECHO_DEPTH  (DEPTH),
      .BUSY_TO     (BTO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rdsig       (rdsig),
      .rxdata      (rxdata),
      .fill_finish (fill_finish),
      .fifo_data   (fifo_data),
      .tx_idle     (tx_idle),
      .wrsig       (wrsig),
      .dataout     (dataout),
      .frame_busy  (frame_busy),
      .frame_done  (frame_done),
      .frame_ovf   (frame_ovf),
      .echo_ovf    (echo_ovf)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Model: frame as a byte array, echo as a queue, one in-flight byte record.
   byte unsigned m_frame[FB];
   byte unsigned m_echo[$];
   int           m_sent, m_age;
   bit           m_busy, m_done, m_fovf, m_eovf, m_wr, m_last_frame;
   bit           m_fly, m_fly_frame, m_low;
   logic [7:0]   m_dout;

   int           s_cyc[$];
   byte unsigned s_dat[$];
   byte unsigned exp_q[$];
   byte unsigned pat[FB];
   int           done_cnt = 0;

   int tx_mode = 0;
   int tx_dly = 0, tx_lo = 0, dly_max = 0, lo_min = 10, lo_max = 10;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      bit complete, g_echo, g_frame, busy_pre;
      logic [FB*8-1:0] tmp;
      if (!reset) begin
         m_sent = 0; m_busy = 0; m_done = 0; m_fovf = 0; m_eovf = 0; m_wr = 0;
         m_dout = 8'h00; m_echo.delete(); m_last_frame = 0; m_fly = 0; m_age = 0; m_low = 0;
         return;
      end
      complete = 0; g_echo = 0; g_frame = 0; m_done = 0; busy_pre = m_busy;
      if (m_fly) begin
         m_age++;
         if (m_age >= 2) begin
            if (!m_low) begin
               if (!tx_idle) m_low = 1;
               else if (m_age - 1 == BTO) complete = 1;
            end else if (tx_idle) complete = 1;
         end
      end else if (tx_idle) begin
         if (m_echo.size() > 0 && (!m_busy || m_last_frame)) g_echo = 1;
         else if (m_busy) g_frame = 1;
      end
      if (g_echo) begin m_dout = m_echo.pop_front(); m_last_frame = 0; end
      if (g_frame) begin m_dout = m_frame[m_sent]; m_last_frame = 1; end
      m_wr = g_echo | g_frame;
      if (m_wr) begin m_fly = 1; m_fly_frame = g_frame; m_age = 0; m_low = 0; end
      if (complete) begin
         m_fly = 0;
         if (m_fly_frame) begin
            m_sent++;
            if (m_sent == FB) begin m_sent = 0; m_busy = 0; m_done = 1; end
         end
      end
      if (fill_finish) begin
         if (busy_pre) m_fovf = 1;
         else begin
            tmp = fifo_data;
            for (int i = 0; i < FB; i++) begin
               m_frame[i] = tmp[FB*8-1 -: 8];
               tmp = tmp << 8;
            end
            m_busy = 1; m_sent = 0;
         end
      end
      if (ECHO_EN && rdsig) begin
         if (m_echo.size() < DEPTH) m_echo.push_back(rxdata);
         else m_eovf = 1;
      end
   endtask

   task automatic tx_step();
      if (tx_mode == 1) tx_idle = 1'b1;
      else if (tx_mode == 2) tx_idle = 1'b0;
      else begin
         if (tx_dly > 0) begin tx_idle = 1'b1; tx_dly--; end
         else if (tx_lo > 0) begin tx_idle = 1'b0; tx_lo--; end
         else tx_idle = 1'b1;
         if (wrsig === 1'b1) begin
            tx_dly = (dly_max > 0) ? int'($urandom_range(dly_max, 0)) : 0;
            tx_lo  = int'($urandom_range(lo_max, lo_min));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      tx_step();
      rdsig = 1'b0;
      fill_finish = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic set_tx(input int mode, input int dmax, input int lmin, input int lmax);
      tx_mode = mode; dly_max = dmax; lo_min = lmin; lo_max = lmax; tx_dly = 0; tx_lo = 0;
   endtask

   task automatic clear_log();
      s_cyc.delete(); s_dat.delete(); exp_q.delete(); done_cnt = 0;
   endtask

   task automatic load_pat();
      for (int i = 0; i < FB; i++) fifo_data = {fifo_data[FB*8-9:0], pat[i]};
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int n = 0;
      while ((m_busy || m_fly || m_echo.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk(name, (m_busy || m_fly || m_echo.size() != 0) ? 32'd1 : 32'd0, 32'd0);
      run(3);
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (i < s_dat.size()) ? 32'(s_dat[i]) : NONE;
   endfunction

   function automatic logic [31:0] gap_at(input int i);
      return (i + 1 < s_cyc.size()) ? 32'(s_cyc[i+1] - s_cyc[i]) : NONE;
   endfunction

   function automatic int log_mismatch();
      int n = 0;
      if (exp_q.size() != s_dat.size()) n++;
      for (int i = 0; i < exp_q.size() && i < s_dat.size(); i++)
         if (exp_q[i] != s_dat[i]) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wrsig", {31'd0, wrsig}, {31'd0, m_wr});
         chk("dataout", {24'd0, dataout}, {24'd0, m_dout});
         chk("frame_busy", {31'd0, frame_busy}, {31'd0, m_busy});
         chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
         chk("frame_ovf", {31'd0, frame_ovf}, {31'd0, m_fovf});
         chk("echo_ovf", {31'd0, echo_ovf}, {31'd0, m_eovf});
      end
      if (wrsig === 1'b1) begin
         s_cyc.push_back(cyc);
         s_dat.push_back(dataout);
      end
      if (frame_done === 1'b1) done_cnt++;
   end

   initial begin
      int n, bad;

      reset = 1'b0;
      run(2);
      chk_en = 1'b1;
      chk("rst_wrsig", {31'd0, wrsig}, 32'd0);
      chk("rst_dataout", {24'd0, dataout}, 32'd0);
      chk("rst_busy", {31'd0, frame_busy}, 32'd0);
      chk("rst_flags", {30'd0, frame_ovf, echo_ovf}, 32'd0);
      reset = 1'b1;
      run(2);

      // Frame only, 0x01..0x24, 10 busy cycles per byte
      set_tx(0, 0, 10, 10);
      clear_log();
      for (int i = 0; i < FB; i++) pat[i] = 8'(i + 1);
      load_pat();
      fill_finish = 1'b1;
      tick();
      chk("ff_busy_n1", {31'd0, frame_busy}, 32'd1);
      chk("ff_wr_n1", {31'd0, wrsig}, 32'd0);
      tick();
      chk("ff_wr_n2", {31'd0, wrsig}, 32'd1);
      chk("ff_dout_n2", {24'd0, dataout}, 32'h01);
      wait_quiet("ff_drain", 2000);
      chk("ff_count", 32'(s_dat.size()), 32'd36);
      chk("ff_first", log_at(0), 32'h01);
      chk("ff_last", log_at(35), 32'h24);
      for (int i = 0; i < FB; i++) exp_q.push_back(8'(i + 1));
      chk("ff_order", 32'(log_mismatch()), 32'd0);
      chk("ff_done_cnt", 32'(done_cnt), 32'd1);
      chk("ff_busy_end", {31'd0, frame_busy}, 32'd0);

      // Echo only
      clear_log();
      rxdata = 8'h41; rdsig = 1'b1;
      tick();
      rxdata = 8'h42; rdsig = 1'b1;
      tick();
      chk("echo_lat", {31'd0, wrsig}, ECHO_EN ? 32'd1 : 32'd0);
      chk("echo_dout", {24'd0, dataout}, ECHO_EN ? 32'h41 : 32'h24);
      wait_quiet("echo_drain", 500);
      chk("echo_count", 32'(s_dat.size()), ECHO_EN ? 32'd2 : 32'd0);
      chk("echo_second", log_at(1), ECHO_EN ? 32'h42 : NONE);
      chk("echo_gap", gap_at(0), ECHO_EN ? 32'd13 : NONE);

      // Contention: frame and 0x55 both waiting when the transmitter frees up
      clear_log();
      for (int i = 0; i < FB; i++) pat[i] = 8'(8'hA0 + i);
      load_pat();
      set_tx(2, 0, 10, 10);
      tick();
      fill_finish = 1'b1; rdsig = 1'b1; rxdata = 8'h55;
      run(3);
      set_tx(0, 0, 4, 9);
      wait_quiet("cont_drain", 2000);
      exp_q.push_back(pat[0]);
      if (ECHO_EN) exp_q.push_back(8'h55);
      for (int i = 1; i < FB; i++) exp_q.push_back(pat[i]);
      chk("cont_count", 32'(s_dat.size()), ECHO_EN ? 32'd37 : 32'd36);
      chk("cont_second", log_at(1), ECHO_EN ? 32'h55 : 32'hA1);
      chk("cont_order", 32'(log_mismatch()), 32'd0);

      // Echo overflow: five bytes into a depth-4 FIFO while the transmitter is busy
      clear_log();
      set_tx(2, 0, 10, 10);
      tick();
      for (int i = 0; i < 5; i++) begin
         rxdata = 8'(8'h61 + i); rdsig = 1'b1;
         tick();
      end
      chk("eovf_flag", {31'd0, echo_ovf}, ECHO_EN ? 32'd1 : 32'd0);
      set_tx(0, 0, 3, 6);
      wait_quiet("eovf_drain", 500);
      chk("eovf_count", 32'(s_dat.size()), ECHO_EN ? 32'd4 : 32'd0);
      if (ECHO_EN) for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h61 + i));
      chk("eovf_order", 32'(log_mismatch()), 32'd0);

      // Frame overflow: second fill_finish mid-frame must not disturb the first
      clear_log();
      for (int i = 0; i < FB; i++) pat[i] = 8'($urandom);
      load_pat();
      fill_finish = 1'b1;
      run(25);
      for (int i = 0; i < FB; i++) exp_q.push_back(pat[i]);
      for (int i = 0; i < FB; i++) pat[i] = 8'($urandom);
      load_pat();
      fill_finish = 1'b1;
      tick();
      chk("fovf_flag", {31'd0, frame_ovf}, 32'd1);
      wait_quiet("fovf_drain", 2000);
      chk("fovf_order", 32'(log_mismatch()), 32'd0);

      // Stuck idle: every byte goes through the timeout path
      clear_log();
      set_tx(1, 0, 1, 1);
      tick();
      for (int i = 0; i < FB; i++) pat[i] = 8'(8'h10 + i);
      load_pat();
      fill_finish = 1'b1;
      tick();
      wait_quiet("stuck_drain", 2000);
      chk("stuck_count", 32'(s_dat.size()), 32'd36);
      bad = 0;
      for (int i = 0; i < FB - 1; i++) if (gap_at(i) != 32'd18) bad++;
      chk("stuck_gaps", 32'(bad), 32'd0);
      chk("stuck_done", 32'(done_cnt), 32'd1);

      // Reset during byte 10, then a fresh frame restarts from byte 0
      clear_log();
      set_tx(0, 0, 10, 10);
      for (int i = 0; i < FB; i++) pat[i] = 8'(8'hC0 + i);
      load_pat();
      fill_finish = 1'b1;
      n = 0;
      while (s_dat.size() < 10 && n < 1000) begin tick(); n++; end
      chk("rst_reach10", (s_dat.size() >= 10) ? 32'd1 : 32'd0, 32'd1);
      run(3);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rstm_wrsig", {31'd0, wrsig}, 32'd0);
      chk("rstm_busy", {31'd0, frame_busy}, 32'd0);
      chk("rstm_flags", {30'd0, frame_ovf, echo_ovf}, 32'd0);
      run(15);
      clear_log();
      fill_finish = 1'b1;
      tick();
      wait_quiet("rstm_drain", 2000);
      chk("rstm_first", log_at(0), 32'hC0);
      chk("rstm_count", 32'(s_dat.size()), 32'd36);

      // Randomized traffic with late, short and missing busy indications
      set_tx(0, 20, 1, 15);
      for (int k = 0; k < 4000; k++) begin
         rdsig  = ($urandom_range(3, 0) == 0);
         rxdata = 8'($urandom);
         if ($urandom_range(60, 0) == 0) begin
            for (int i = 0; i < FB; i++) pat[i] = 8'($urandom);
            load_pat();
            fill_finish = 1'b1;
         end
         reset = ($urandom_range(1500, 0) != 0);
         tick();
      end
      reset = 1'b1;
      wait_quiet("rand_drain", 5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
